ahb_master_mux: RTL and testbench

//  Two-master AHB-Lite bus mux (CPU = master 0, DMA = master 1) that sits directly downstream of the arbiter.
//  - Turns each master's HTRANS into a request to the arbiter, and samples the arbiter's grants only at safe handoff points.
//  - Drives the shared address/control from the address-phase owner and the shared HWDATA from the data-phase owner.
//  - Routes HREADY/HRESP back to the masters and stalls any master that is not the owner.

---
 rtl/ahb_pkg.sv | 31 +++
 rtl/ahb_ctrl_mux2.sv | 23 ++
 rtl/ahb_master_mux.sv | 134 +++++++++++++
 tb/tb_ahb_master_mux.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the two-master bus mux.
package ahb_pkg;

    // HTRANS transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HRESP values
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Bus phase owner
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DMA  = 2'b10
    } owner_t;

    // Owner chosen at a handoff point; CPU has priority when both grants are high.
    function automatic owner_t grant_owner(input logic cpu_grant, input logic dma_grant);
        if (cpu_grant)
            return OWN_CPU;
        else if (dma_grant)
            return OWN_DMA;
        else
            return OWN_NONE;
    endfunction

endpackage

// File: rtl/ahb_ctrl_mux2.sv
// 2:1 mux with an all-zero default, selected by a bus phase owner.
module ahb_ctrl_mux2
    import ahb_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  owner_t         sel,
    input  logic [W-1:0]   in_cpu,
    input  logic [W-1:0]   in_dma,
    output logic [W-1:0]   out
);

    // Select the owner's bundle; no owner drives all zeros (IDLE for HTRANS).
    always_comb begin
        out = '0;
        case (sel)
            OWN_CPU: out = in_cpu;
            OWN_DMA: out = in_dma;
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/ahb_master_mux.sv
// Two-master AHB-Lite bus mux (CPU = master 0, DMA = master 1) placed after the arbiter.
// Tracks address- and data-phase owners, muxes the shared bus and routes HREADY/HRESP.
module ahb_master_mux
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cpu_grant,
    input  logic              dma_grant,
    output logic              cpu_req,
    output logic              dma_req,
    input  logic [ADDR_W-1:0] cpu_HADDR,
    input  logic [1:0]        cpu_HTRANS,
    input  logic              cpu_HWRITE,
    input  logic [2:0]        cpu_HSIZE,
    input  logic [2:0]        cpu_HBURST,
    input  logic [DATA_W-1:0] cpu_HWDATA,
    output logic [DATA_W-1:0] cpu_HRDATA,
    output logic              cpu_HREADY,
    output logic              cpu_HRESP,
    input  logic [ADDR_W-1:0] dma_HADDR,
    input  logic [1:0]        dma_HTRANS,
    input  logic              dma_HWRITE,
    input  logic [2:0]        dma_HSIZE,
    input  logic [2:0]        dma_HBURST,
    input  logic [DATA_W-1:0] dma_HWDATA,
    output logic [DATA_W-1:0] dma_HRDATA,
    output logic              dma_HREADY,
    output logic              dma_HRESP,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    localparam int unsigned CTRL_W = ADDR_W + 2 + 1 + 3 + 3;

    owner_t            addr_owner;
    owner_t            data_owner;
    logic [1:0]        owner_trans;
    logic              handoff;
    logic [CTRL_W-1:0] cpu_ctrl;
    logic [CTRL_W-1:0] dma_ctrl;
    logic [CTRL_W-1:0] bus_ctrl;
    logic              cpu_owns;
    logic              dma_owns;

    assign cpu_req = cpu_HTRANS[1];
    assign dma_req = dma_HTRANS[1];

    // HTRANS of the current address-phase owner; IDLE when nobody owns the bus.
    always_comb begin
        owner_trans = HTRANS_IDLE;
        case (addr_owner)
            OWN_CPU: owner_trans = cpu_HTRANS;
            OWN_DMA: owner_trans = dma_HTRANS;
            default: owner_trans = HTRANS_IDLE;
        endcase
    end

    // BUSY/NONSEQ/SEQ never hand off, which locks bursts to their owner.
    assign handoff = HREADY && ((addr_owner == OWN_NONE) || (owner_trans == HTRANS_IDLE));

    // Owner registers: address owner moves only at handoff, data owner follows on every accepted phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_owner <= OWN_NONE;
            data_owner <= OWN_NONE;
        end else begin
            if (handoff)
                addr_owner <= grant_owner(cpu_grant, dma_grant);
            if (HREADY)
                data_owner <= addr_owner;
        end
    end

    assign cpu_ctrl = {cpu_HADDR, cpu_HTRANS, cpu_HWRITE, cpu_HSIZE, cpu_HBURST};
    assign dma_ctrl = {dma_HADDR, dma_HTRANS, dma_HWRITE, dma_HSIZE, dma_HBURST};

    ahb_ctrl_mux2 #(.W(CTRL_W)) u_addr_mux (
        .sel    (addr_owner),
        .in_cpu (cpu_ctrl),
        .in_dma (dma_ctrl),
        .out    (bus_ctrl)
    );

    assign {HADDR, HTRANS, HWRITE, HSIZE, HBURST} = bus_ctrl;

    ahb_ctrl_mux2 #(.W(DATA_W)) u_wdata_mux (
        .sel    (data_owner),
        .in_cpu (cpu_HWDATA),
        .in_dma (dma_HWDATA),
        .out    (HWDATA)
    );

    assign cpu_HRDATA = HRDATA;
    assign dma_HRDATA = HRDATA;

    assign cpu_owns = (addr_owner == OWN_CPU) || (data_owner == OWN_CPU);
    assign dma_owns = (addr_owner == OWN_DMA) || (data_owner == OWN_DMA);

    // Owners see the bus ready; a non-owner presenting an active transfer is stalled.
    always_comb begin
        cpu_HREADY = 1'b1;
        dma_HREADY = 1'b1;
        if (cpu_owns)
            cpu_HREADY = HREADY;
        else if (cpu_HTRANS[1])
            cpu_HREADY = 1'b0;
        if (dma_owns)
            dma_HREADY = HREADY;
        else if (dma_HTRANS[1])
            dma_HREADY = 1'b0;
    end

    // Responses belong to the data phase, so only the data owner sees HRESP.
    always_comb begin
        cpu_HRESP = HRESP_OKAY;
        dma_HRESP = HRESP_OKAY;
        if (data_owner == OWN_CPU)
            cpu_HRESP = HRESP;
        if (data_owner == OWN_DMA)
            dma_HRESP = HRESP;
    end

endmodule

// File: tb/tb_ahb_master_mux.sv
// Directed self-checking bench for ahb_master_mux.
module tb_ahb_master_mux;
    import ahb_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cpu_grant, dma_grant;
    logic        cpu_req, dma_req;
    logic [31:0] cpu_HADDR, dma_HADDR;
    logic [1:0]  cpu_HTRANS, dma_HTRANS;
    logic        cpu_HWRITE, dma_HWRITE;
    logic [2:0]  cpu_HSIZE, dma_HSIZE, cpu_HBURST, dma_HBURST;
    logic [31:0] cpu_HWDATA, dma_HWDATA, cpu_HRDATA, dma_HRDATA;
    logic        cpu_HREADY, dma_HREADY, cpu_HRESP, dma_HRESP;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [31:0] HWDATA, HRDATA;
    logic        HREADY, HRESP;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 HCLK = ~HCLK;

    ahb_master_mux #(.ADDR_W(32), .DATA_W(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cpu_grant(cpu_grant), .dma_grant(dma_grant),
        .cpu_req(cpu_req), .dma_req(dma_req),
        .cpu_HADDR(cpu_HADDR), .cpu_HTRANS(cpu_HTRANS), .cpu_HWRITE(cpu_HWRITE),
        .cpu_HSIZE(cpu_HSIZE), .cpu_HBURST(cpu_HBURST), .cpu_HWDATA(cpu_HWDATA),
        .cpu_HRDATA(cpu_HRDATA), .cpu_HREADY(cpu_HREADY), .cpu_HRESP(cpu_HRESP),
        .dma_HADDR(dma_HADDR), .dma_HTRANS(dma_HTRANS), .dma_HWRITE(dma_HWRITE),
        .dma_HSIZE(dma_HSIZE), .dma_HBURST(dma_HBURST), .dma_HWDATA(dma_HWDATA),
        .dma_HRDATA(dma_HRDATA), .dma_HREADY(dma_HREADY), .dma_HRESP(dma_HRESP),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs driven after this settle before the next check.
    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic owners(input string tag, input owner_t a, input owner_t d);
        check({tag, ".addr_owner"}, 64'(dut.addr_owner), 64'(a));
        check({tag, ".data_owner"}, 64'(dut.data_owner), 64'(d));
    endtask

    task automatic idle_all();
        cpu_HTRANS = HTRANS_IDLE; dma_HTRANS = HTRANS_IDLE;
        cpu_grant = 1'b0; dma_grant = 1'b0;
        HREADY = 1'b1; HRESP = 1'b0;
        cyc(); cyc();
    endtask

    initial begin
        HRESETn = 1'b0;
        cpu_grant = 0; dma_grant = 0;
        cpu_HADDR = '0; cpu_HTRANS = HTRANS_IDLE; cpu_HWRITE = 0; cpu_HSIZE = 3'd2; cpu_HBURST = 0; cpu_HWDATA = '0;
        dma_HADDR = '0; dma_HTRANS = HTRANS_IDLE; dma_HWRITE = 0; dma_HSIZE = 3'd2; dma_HBURST = 0; dma_HWDATA = '0;
        HRDATA = 32'h1234_5678; HREADY = 1'b1; HRESP = 1'b0;

        // 1. reset, both idle
        #12;
        check("t1.HTRANS", 64'(HTRANS), 64'(HTRANS_IDLE));
        check("t1.HADDR", 64'(HADDR), 64'h0);
        check("t1.HWDATA", 64'(HWDATA), 64'h0);
        check("t1.cpu_HREADY", 64'(cpu_HREADY), 64'h1);
        check("t1.dma_HREADY", 64'(dma_HREADY), 64'h1);
        owners("t1", OWN_NONE, OWN_NONE);
        cpu_HTRANS = HTRANS_NONSEQ; #1;
        check("t1.cpu_HREADY_active_in_reset", 64'(cpu_HREADY), 64'h0);
        check("t1.cpu_req", 64'(cpu_req), 64'h1);
        check("t1.dma_HRDATA", 64'(dma_HRDATA), 64'h1234_5678);
        cpu_HTRANS = HTRANS_IDLE;
        cyc();
        HRESETn = 1'b1;
        cyc();

        // 2. CPU single write
        cpu_HTRANS = HTRANS_NONSEQ; cpu_HADDR = 32'h1000; cpu_HWRITE = 1'b1; cpu_grant = 1'b1; #1;
        check("t2.HTRANS_before_grant", 64'(HTRANS), 64'(HTRANS_IDLE));
        check("t2.cpu_HREADY_stall", 64'(cpu_HREADY), 64'h0);
        cyc();
        check("t2.HADDR", 64'(HADDR), 64'h1000);
        check("t2.HTRANS", 64'(HTRANS), 64'(HTRANS_NONSEQ));
        check("t2.HWRITE", 64'(HWRITE), 64'h1);
        check("t2.cpu_HREADY", 64'(cpu_HREADY), 64'h1);
        cpu_HTRANS = HTRANS_IDLE; cpu_HWDATA = 32'hCAFE;
        cyc();
        check("t2.HWDATA", 64'(HWDATA), 64'hCAFE);
        owners("t2", OWN_CPU, OWN_CPU);
        HREADY = 1'b0; #1;
        check("t2.cpu_HREADY_low", 64'(cpu_HREADY), 64'h0);
        HREADY = 1'b1; #1;
        check("t2.cpu_HREADY_high", 64'(cpu_HREADY), 64'h1);
        cpu_HWRITE = 1'b0;
        idle_all();
        owners("t2.cleared", OWN_NONE, OWN_NONE);

        // 3. CPU INCR4 burst, DMA request stalled until CPU goes IDLE
        cpu_HTRANS = HTRANS_NONSEQ; cpu_HADDR = 32'h2000; cpu_HBURST = 3'b011; cpu_grant = 1'b1;
        cyc();
        cpu_grant = 1'b0; dma_grant = 1'b1;
        dma_HTRANS = HTRANS_NONSEQ; dma_HADDR = 32'h3000; #1;
        check("t3.beat1_HADDR", 64'(HADDR), 64'h2000);
        check("t3.dma_stall_b1", 64'(dma_HREADY), 64'h0);
        for (int unsigned b = 1; b < 4; b++) begin
            cpu_HTRANS = HTRANS_SEQ; cpu_HADDR = 32'h2000 + 32'(4 * b);
            cyc();
            check($sformatf("t3.beat%0d_HADDR", b + 1), 64'(HADDR), 64'h2000 + 64'(4 * b));
            check($sformatf("t3.dma_stall_b%0d", b + 1), 64'(dma_HREADY), 64'h0);
        end
        cpu_HTRANS = HTRANS_IDLE; #1;
        check("t3.cpu_idle_on_bus", 64'(HTRANS), 64'(HTRANS_IDLE));
        check("t3.dma_still_stalled", 64'(dma_HREADY), 64'h0);
        cyc();
        check("t3.dma_HADDR", 64'(HADDR), 64'h3000);
        check("t3.dma_HTRANS", 64'(HTRANS), 64'(HTRANS_NONSEQ));
        check("t3.dma_HREADY", 64'(dma_HREADY), 64'h1);
        owners("t3", OWN_DMA, OWN_CPU);
        cpu_HBURST = 3'b000;
        idle_all();

        // 4. Both request from NONE with both grants: CPU first
        cpu_HTRANS = HTRANS_NONSEQ; cpu_HADDR = 32'h4000;
        dma_HTRANS = HTRANS_NONSEQ; dma_HADDR = 32'h5000;
        cpu_grant = 1'b1; dma_grant = 1'b1;
        cyc();
        check("t4.cpu_first", 64'(HADDR), 64'h4000);
        check("t4.dma_wait", 64'(dma_HREADY), 64'h0);
        cpu_HTRANS = HTRANS_IDLE; cpu_grant = 1'b0;
        cyc();
        check("t4.dma_second", 64'(HADDR), 64'h5000);
        check("t4.dma_HREADY", 64'(dma_HREADY), 64'h1);
        idle_all();

        // 5. Wait states in CPU data phase while dma_grant toggles
        cpu_HTRANS = HTRANS_NONSEQ; cpu_HADDR = 32'h6000; cpu_grant = 1'b1;
        cyc();
        cpu_HTRANS = HTRANS_IDLE;
        cyc();
        owners("t5.start", OWN_CPU, OWN_CPU);
        cpu_grant = 1'b0; HREADY = 1'b0;
        for (int unsigned w = 0; w < 3; w++) begin
            dma_grant = (w % 2 == 0);
            cyc();
            owners($sformatf("t5.wait%0d", w), OWN_CPU, OWN_CPU);
            check($sformatf("t5.cpu_HREADY%0d", w), 64'(cpu_HREADY), 64'h0);
            check($sformatf("t5.dma_HREADY%0d", w), 64'(dma_HREADY), 64'h1);
        end
        idle_all();

        // 6. Two-cycle ERROR on a DMA read
        dma_HTRANS = HTRANS_NONSEQ; dma_HADDR = 32'h8000; dma_HWRITE = 1'b0; dma_grant = 1'b1;
        cyc();
        dma_HTRANS = HTRANS_IDLE; dma_grant = 1'b0;
        cyc();
        HREADY = 1'b0; HRESP = HRESP_ERROR; #1;
        check("t6.err1_dma_HRESP", 64'(dma_HRESP), 64'h1);
        check("t6.err1_cpu_HRESP", 64'(cpu_HRESP), 64'h0);
        check("t6.err1_dma_HREADY", 64'(dma_HREADY), 64'h0);
        cyc();
        HREADY = 1'b1; #1;
        check("t6.err2_dma_HRESP", 64'(dma_HRESP), 64'h1);
        check("t6.err2_cpu_HRESP", 64'(cpu_HRESP), 64'h0);
        check("t6.err2_dma_HREADY", 64'(dma_HREADY), 64'h1);
        idle_all();
        check("t6.after_dma_HRESP", 64'(dma_HRESP), 64'h0);

        // 7. Reset mid DMA burst
        dma_HTRANS = HTRANS_NONSEQ; dma_HADDR = 32'h9000; dma_HBURST = 3'b011; dma_grant = 1'b1;
        cyc();
        dma_HTRANS = HTRANS_SEQ; dma_HADDR = 32'h9004;
        cyc();
        check("t7.burst_HTRANS", 64'(HTRANS), 64'(HTRANS_SEQ));
        #2 HRESETn = 1'b0;
        #1;
        check("t7.HTRANS", 64'(HTRANS), 64'(HTRANS_IDLE));
        check("t7.HADDR", 64'(HADDR), 64'h0);
        owners("t7", OWN_NONE, OWN_NONE);
        check("t7.dma_HREADY", 64'(dma_HREADY), 64'h0);
        cyc();
        HRESETn = 1'b1;
        idle_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
